// File: rtl/uart_fifo_pkg.sv
// Shared helpers for the UART TX ring FIFO: pointer/count widths, wrapping
// pointer increment and the status bundle consumed by the status reporter.
package uart_fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic overflow;
    } fifo_status_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wraps at depth-1 rather than relying on binary rollover, so any DEPTH works.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DATA_WIDTH x DEPTH register array: one synchronous write port and one
// combinational read port, cleared by the asynchronous reset.
module uart_fifo_mem
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [ptr_width(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [ptr_width(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]       rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array is reset because out_data must read zero straight after
    // reset; a reset-free array would map to denser RAM but expose stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_tx_ring_fifo.sv
// Circular-buffer TX FIFO between the byte sources and the UART transmitter:
// valid/ready on both sides, occupancy count, almost-full, sticky overflow, flush.
module uart_tx_ring_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ena,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         overflow,
    input  logic                         clear_overflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_ovf_set;

    // Status comes only from the registered count, so no input reaches it combinationally.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    assign in_ready  = ena & ~w_full;
    assign out_valid = ena & ~w_empty;

    assign w_push    = in_valid  & in_ready  & ~flush;
    assign w_pop     = out_ready & out_valid & ~flush;
    assign w_ovf_set = ena & in_valid & w_full & ~flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (ena) begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= PTR_W'(ptr_inc(32'(r_wr_ptr), 32'(DEPTH)));
                end
                if (w_pop) begin
                    r_rd_ptr <= PTR_W'(ptr_inc(32'(r_rd_ptr), 32'(DEPTH)));
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (in_data),
        .raddr (r_rd_ptr),
        .rdata (out_data)
    );

    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= CNT_W'(ALMOST_FULL_LEVEL));
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_tx_ring_fifo.sv
// Self-checking bench for uart_tx_ring_fifo (DEPTH=4, ALMOST_FULL_LEVEL=3):
// queue-based reference model compared every cycle, plus directed literal checks.
module tb_uart_tx_ring_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          ena;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic          clear_overflow;

    int errors = 0;
    int checks = 0;

    byte unsigned m_q[$];
    bit           m_ov = 1'b0;
    int           m_size;
    byte unsigned dut_log[$];

    uart_tx_ring_fifo #(
        .DATA_WIDTH        (DW),
        .DEPTH             (DEPTH),
        .ALMOST_FULL_LEVEL (AFL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ena            (ena),
        .flush          (flush),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO queue updated by the handshake rules at each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_ov = 1'b0;
        end else if (ena) begin
            m_size = m_q.size();
            if (!flush && in_valid && m_size == DEPTH) m_ov = 1'b1;
            else if (clear_overflow)                   m_ov = 1'b0;
            if (flush) begin
                m_q.delete();
            end else begin
                if (out_ready && m_size > 0)     void'(m_q.pop_front());
                if (in_valid && m_size < DEPTH)  m_q.push_back(in_data);
            end
        end
    end

    // Every-cycle comparison on the falling edge, away from state updates.
    always @(negedge clk) begin
        check("cmp_in_ready",    {31'b0, in_ready},    {31'b0, ena && m_q.size() < DEPTH});
        check("cmp_out_valid",   {31'b0, out_valid},   {31'b0, ena && m_q.size() > 0});
        check("cmp_count",       {29'b0, count},       m_q.size());
        check("cmp_empty",       {31'b0, empty},       {31'b0, m_q.size() == 0});
        check("cmp_full",        {31'b0, full},        {31'b0, m_q.size() == DEPTH});
        check("cmp_almost_full", {31'b0, almost_full}, {31'b0, m_q.size() >= AFL});
        check("cmp_overflow",    {31'b0, overflow},    {31'b0, m_ov});
        if (ena && m_q.size() > 0) check("cmp_out_data", {24'b0, out_data}, {24'b0, m_q[0]});
        if (!reset && ena && !flush && out_valid && out_ready) dut_log.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 expected end earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp3 [8];
        int         base;
        int         n05;
        int         n99;

        exp3 = '{8'hA2, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};

        reset = 1'b1; ena = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; clear_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",     {29'b0, count},     0);
        check("rst_empty",     {31'b0, empty},     1);
        check("rst_in_ready",  {31'b0, in_ready},  1);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_data",  {24'b0, out_data},  0);
        check("rst_af",        {31'b0, almost_full}, 0);
        reset = 1'b0;

        // 1: order and latency
        push(8'h41);
        check("t1_cnt1", {29'b0, count}, 1);
        check("t1_data_first", {24'b0, out_data}, 8'h41);
        push(8'h42);
        check("t1_af_at2", {31'b0, almost_full}, 0);
        push(8'h43);
        check("t1_cnt3", {29'b0, count}, 3);
        check("t1_af_at3", {31'b0, almost_full}, 1);
        out_ready = 1'b1;
        tick();
        check("t1_data_42", {24'b0, out_data}, 8'h42);
        check("t1_cnt2", {29'b0, count}, 2);
        tick();
        check("t1_data_43", {24'b0, out_data}, 8'h43);
        tick();
        check("t1_empty_end", {31'b0, empty}, 1);
        out_ready = 1'b0;

        // 2: full and overflow
        for (int i = 1; i <= 4; i++) push(8'(i));
        check("t2_in_ready_full", {31'b0, in_ready}, 0);
        check("t2_full",          {31'b0, full},     1);
        check("t2_ovf_before",    {31'b0, overflow}, 0);
        push(8'h05);
        check("t2_ovf_set", {31'b0, overflow}, 1);
        check("t2_cnt4",    {29'b0, count},    4);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("t2_ovf_clr", {31'b0, overflow}, 0);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("t2_drained", {29'b0, count}, 0);

        // 3: simultaneous push/pop across the wrap point (pointers start at 0)
        reset = 1'b1; #1; reset = 1'b0;
        push(8'hA0); push(8'hA1); push(8'hA2);
        out_ready = 1'b1;
        repeat (2) tick();
        check("t3_cnt1_pre", {29'b0, count}, 1);
        base = dut_log.size();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            tick();
            check($sformatf("t3_cnt_stream%0d", i), {29'b0, count}, 1);
        end
        in_valid = 1'b0;
        check("t3_log_len", dut_log.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < dut_log.size())
                check($sformatf("t3_seq%0d", i), {24'b0, dut_log[base + i]}, {24'b0, exp3[i]});
        end
        check("t3_last", {24'b0, out_data}, 8'h17);
        tick();
        out_ready = 1'b0;
        check("t3_empty", {31'b0, empty}, 1);

        // 4: flush beats push
        push(8'h21); push(8'h22);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_cnt0",      {29'b0, count},     0);
        check("t4_empty",     {31'b0, empty},     1);
        check("t4_out_valid", {31'b0, out_valid}, 0);
        check("t4_ovf",       {31'b0, overflow},  0);

        // 5: enable freeze
        push(8'h31); push(8'h32);
        ena = 1'b0; in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_in_ready", {31'b0, in_ready},  0);
            check("t5_out_valid", {31'b0, out_valid}, 0);
            check("t5_cnt2",     {29'b0, count},     2);
        end
        ena = 1'b1; in_valid = 1'b0;
        check("t5_data_31", {24'b0, out_data}, 8'h31);
        tick();
        check("t5_data_32", {24'b0, out_data}, 8'h32);
        tick();
        out_ready = 1'b0;
        check("t5_cnt0", {29'b0, count}, 0);

        // 6: asynchronous reset between edges
        push(8'h61); push(8'h62); push(8'h63);
        check("t6_cnt3", {29'b0, count}, 3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_async_cnt",   {29'b0, count},     0);
        check("t6_async_valid", {31'b0, out_valid}, 0);
        check("t6_async_data",  {24'b0, out_data},  0);
        @(posedge clk);
        #1 reset = 1'b0;
        push(8'h55);
        check("t6_valid_55", {31'b0, out_valid}, 1);
        check("t6_data_55",  {24'b0, out_data},  8'h55);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t6_cnt0", {29'b0, count}, 0);

        n05 = 0;
        n99 = 0;
        foreach (dut_log[i]) begin
            if (dut_log[i] == 8'h05) n05++;
            if (dut_log[i] == 8'h99) n99++;
        end
        check("never_out_05", n05, 0);
        check("never_out_99", n99, 0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ring_fifo.md
Name: uart_tx_ring_fifo

Overview:
Parametrised circular-buffer FIFO that sits between the byte sources (command parser, status reporter) and the UART transmitter. It replaces the shift-register TX FIFO with these changes:
- pointer-based storage, so data never moves;
- true valid/ready flow control on both sides;
- occupancy count and almost-full threshold;
- sticky overflow flag and synchronous flush.
Output order is strict first-in, first-out.

Parameters:
- DATA_WIDTH, 8: bits per character.
- DEPTH, 16: number of entries; any value >= 2, not required to be a power of two.
- ALMOST_FULL_LEVEL, DEPTH-2: almost_full asserts when count >= this value; legal range 1..DEPTH.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous active-high reset.
- ena  in  1  design enable; when low, the FIFO freezes.
- flush  in  1  synchronous clear of contents.
- in_data  in  DATA_WIDTH  character to enqueue.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO accepts a write this cycle.
- out_data  out  DATA_WIDTH  head-of-queue character.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  transmitter consumes the head this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- overflow  out  1  sticky flag: a write was attempted while full.
- clear_overflow  in  1  clears overflow.

Behaviour:
- Reset (asynchronous, active-high): wr_ptr=0, rd_ptr=0, count=0, overflow=0, all storage=0. Resulting outputs: in_ready=ena, out_valid=0, out_data=0, empty=1, full=0, almost_full=0.
- Reset asserted mid-operation discards all contents immediately, with no clock edge needed.
- Handshake rules:
  - push = ena & in_valid & in_ready.
  - pop = ena & out_valid & out_ready.
  - in_ready = ena & !full. It must not depend on out_ready; there is no combinational ready path.
  - out_valid = ena & !empty.
  - out_data = mem[rd_ptr], driven combinationally from storage.
- Latency: a character pushed at edge N is visible at out_valid/out_data after edge N (one cycle write-to-read). If out_ready is held high, it can be popped at edge N+1.
- Pointers:
  - Each pointer is $clog2(DEPTH) bits.
  - Increment wraps explicitly: ptr == DEPTH-1 goes to 0. No reliance on natural binary rollover.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; both pointers advance.
- Full: in_ready=0, so a simultaneous push and pop while full performs the pop only.
- Empty: out_valid=0, so no pop occurs and out_data holds the stale value.
- Overflow:
  - Set when ena & in_valid & full, and flush is not asserted.
  - Cleared by clear_overflow.
  - If set and clear occur in the same cycle, set wins.
  - Not affected by flush; cleared only by reset or clear_overflow.
- Flush (sampled only when ena=1):
  - wr_ptr, rd_ptr and count go to 0; storage contents are left untouched.
  - Takes precedence over any push or pop in the same cycle; that cycle's push is dropped and does not set overflow.
- ena=0: no pointer, count, storage or overflow change. in_ready=0 and out_valid=0. Status outputs (count, empty, full, almost_full) keep showing the held state.
- All status outputs are decoded from the registered count; there are no glitch paths from the inputs.

Decomposition:
- Package uart_fifo_pkg holds:
  - function ptr_inc(ptr, depth), the wrapping increment;
  - localparam helpers PTR_W = $clog2(DEPTH) and CNT_W = $clog2(DEPTH+1);
  - typedef fifo_status_t, a struct of empty, full, almost_full and overflow, for use by the status reporter.
- One sub-module: uart_fifo_mem.
  - DATA_WIDTH x DEPTH register array.
  - Single write port: we, waddr, wdata.
  - Combinational read port: raddr, rdata.
  - Asynchronous reset clears the array.
- Pointer, count and flag logic lives in uart_tx_ring_fifo.

Test Plan (DEPTH=4, ALMOST_FULL_LEVEL=3, DATA_WIDTH=8):
1. Order and latency: push 0x41, 0x42, 0x43 on consecutive cycles with out_ready=0, then raise out_ready. Required: out_data reads 0x41, 0x42, 0x43 on successive cycles; count goes 1,2,3 then 2,1,0; almost_full is high only while count=3; empty=1 at the end.
2. Full and overflow: push 5 characters 0x01..0x05 with out_ready=0. Required: in_ready drops after the 4th push; full=1; overflow=1 from the 5th cycle; 0x05 is never output. Then pulse clear_overflow; required: overflow=0.
3. Simultaneous push and pop at wrap-around:
   - Fill to 3, then drain 2, so rd_ptr=2 and wr_ptr=3.
   - Stream 0x10..0x17 with in_valid=out_ready=1 for 8 cycles.
   - Required: output sequence is the remaining original byte followed by 0x10..0x16 in order, and count stays at 1 throughout.
4. Flush versus push: with count=2, assert flush and in_valid(0x99) in the same cycle. Required: next cycle count=0, empty=1, out_valid=0, overflow unchanged; 0x99 is never output.
5. Enable freeze: with count=2, drop ena for 3 cycles while driving in_valid=out_ready=1. Required: in_ready=out_valid=0 and count stays 2. Raise ena; required: original data resumes in order.
6. Asynchronous reset mid-stream: assert reset between clock edges while count=3. Required: count=0, out_valid=0, out_data=0 before the next edge; after release, a push of 0x55 is output after 1 cycle.
